// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared swap encodings, issue FSM states and the word swap helper
//   swap_word(data, mode, nbytes): transform of the low nbytes of data; upper bytes unused.

package rom_loader_pkg;

    localparam logic [1:0] SWAP_NONE = 2'd0;
    localparam logic [1:0] SWAP_BIT  = 2'd1;
    localparam logic [1:0] SWAP_BYTE = 2'd2;
    localparam logic [1:0] SWAP_BOTH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } issue_state_t;

    // Bit reversal is applied per byte first, then the byte order of the
    // nbytes-wide word is reversed; for mode BOTH the two commute anyway.
    function automatic logic [63:0] swap_word(input logic [63:0] data,
                                              input logic [1:0]  mode,
                                              input int          nbytes);
        logic        bit_rev;
        logic        byte_rev;
        logic [63:0] bits_done;
        logic [63:0] result;
        bit_rev  = 1'b0;
        byte_rev = 1'b0;
        case (mode)
            SWAP_NONE: begin bit_rev = 1'b0; byte_rev = 1'b0; end
            SWAP_BIT:  begin bit_rev = 1'b1; byte_rev = 1'b0; end
            SWAP_BYTE: begin bit_rev = 1'b0; byte_rev = 1'b1; end
            SWAP_BOTH: begin bit_rev = 1'b1; byte_rev = 1'b1; end
        endcase
        bits_done = data;
        if (bit_rev) begin
            for (int b = 0; b < 8; b++) begin
                for (int k = 0; k < 8; k++) begin
                    bits_done[b*8+k] = data[b*8+7-k];
                end
            end
        end
        result = bits_done;
        if (byte_rev) begin
            for (int b = 0; b < 8; b++) begin
                if (b < nbytes) begin
                    result[b*8 +: 8] = bits_done[(nbytes-1-b)*8 +: 8];
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and occupancy count
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : discard contents; a push in the same cycle becomes the only entry
//   push, wdata       : write strobe and data (caller guarantees not full unless flushing)
//   pop, rdata        : read strobe; rdata shows the head combinationally
//   count, empty, full: occupancy status

module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_slot;

    assign wr_slot = flush ? '0 : wr_ptr;
    assign rdata   = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= PW'(push);
            rd_ptr <= '0;
            count  <= CW'(push);
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_slot] <= wdata;
    end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - buffered ioctl ROM download into ddram with swap, size and copier-header detect
//   clk_sys, reset_n            : clock, asynchronous active-low reset
//   ioctl_download/wr/dout/wait : hps_io download side
//   swap_mode                   : 0 none, 1 bit-reverse per byte, 2 byte-reverse, 3 both
//   mem_addr/din/req, mem_ack   : toggle req/ack write port to the memory controller
//   rom_size, hdr_present/offset: download size and header detection result
//   done, overflow              : completion pulse, sticky dropped-write flag

module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 24,
    parameter int DEPTH     = 4,
    parameter int HDR_BYTES = 512,
    parameter int HDR_ALIGN = 1024
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [DW-1:0] ioctl_dout,
    output logic          ioctl_wait,
    input  logic [1:0]    swap_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-1:0] rom_size,
    output logic          hdr_present,
    output logic [AW-1:0] hdr_offset,
    output logic          done,
    output logic          overflow
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] STEP = AW'(DW / 8);

    issue_state_t  state;
    logic          dl_q;
    logic          pending;
    logic          dl_start;
    logic          dl_end;
    logic          wr_req;
    logic          push;
    logic          pop;
    logic          req_idle;
    logic          hdr_hit;
    logic [DW-1:0] swapped;
    logic [DW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;
    logic          fifo_empty;
    logic          fifo_full;

    assign dl_start = ioctl_download & ~dl_q;
    assign dl_end   = ~ioctl_download & dl_q;
    assign wr_req   = ioctl_wr & ioctl_download;
    // The flush on a start edge empties the FIFO, so a strobe in that cycle always fits.
    assign push     = wr_req & (dl_start | ~fifo_full);
    // A start edge aborts an ISSUE cycle; the flush discards the head anyway.
    assign pop      = (state == ST_ISSUE) & ~dl_start;
    assign req_idle = (mem_req == mem_ack);
    assign hdr_hit  = ((rom_size & AW'(HDR_ALIGN - 1)) == AW'(HDR_BYTES));
    assign swapped  = DW'(swap_word(64'(ioctl_dout), swap_mode, DW / 8));

    always_comb begin
        if (dl_start) count_nxt = CW'(push);
        else          count_nxt = fifo_count + CW'(push) - CW'(pop);
    end

    sync_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .flush (dl_start),
        .push  (push),
        .wdata (swapped),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dl_q        <= 1'b0;
            pending     <= 1'b0;
            ioctl_wait  <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_req     <= 1'b0;
            rom_size    <= '0;
            hdr_present <= 1'b0;
            hdr_offset  <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            done       <= 1'b0;
            ioctl_wait <= (count_nxt >= CW'(DEPTH - 1));
            if (dl_start) begin
                // Returning to IDLE keeps an in-flight request honoured: IDLE
                // only issues again once mem_ack has caught up with mem_req.
                state       <= ST_IDLE;
                pending     <= 1'b0;
                mem_addr    <= '0;
                rom_size    <= push ? STEP : '0;
                hdr_present <= 1'b0;
                hdr_offset  <= '0;
                overflow    <= 1'b0;
            end else begin
                if (push)               rom_size <= rom_size + STEP;
                if (wr_req & fifo_full) overflow <= 1'b1;
                if (dl_end)             pending  <= 1'b1;
                case (state)
                    ST_IDLE: begin
                        if (!fifo_empty && req_idle) begin
                            state <= ST_ISSUE;
                        end else if (pending && fifo_empty && req_idle) begin
                            done        <= 1'b1;
                            pending     <= 1'b0;
                            hdr_present <= hdr_hit;
                            hdr_offset  <= hdr_hit ? AW'(HDR_BYTES) : '0;
                        end
                    end
                    ST_ISSUE: begin
                        mem_din <= fifo_rdata;
                        mem_req <= ~mem_req;
                        state   <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (req_idle) begin
                            mem_addr <= mem_addr + STEP;
                            state    <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed self-checking bench for rom_loader

module tb_rom_loader;
    import rom_loader_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [1:0]  swap_mode;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_req;
    logic        mem_ack;
    logic [23:0] rom_size;
    logic        hdr_present;
    logic [23:0] hdr_offset;
    logic        done;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 3;
    int ack_cnt;
    logic req_seen;
    int done_cnt = 0;
    int proto_err = 0;
    logic [23:0] log_addr[$];
    logic [15:0] log_data[$];

    rom_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .swap_mode      (swap_mode),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .rom_size       (rom_size),
        .hdr_present    (hdr_present),
        .hdr_offset     (hdr_offset),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory model: logs every request toggle and echoes it ack_delay cycles later.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_ack  <= 1'b0;
            req_seen <= 1'b0;
            ack_cnt  <= 0;
        end else if (mem_req != req_seen) begin
            if (ack_cnt != 0) proto_err++;
            req_seen <= mem_req;
            ack_cnt  <= ack_delay;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_din);
        end else if (ack_cnt != 0) begin
            ack_cnt <= ack_cnt - 1;
            if (ack_cnt == 1) mem_ack <= req_seen;
        end
    end

    always @(posedge clk_sys) if (done === 1'b1) done_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic write_word(input logic [15:0] d, output bit ok);
        int t = 0;
        while (ioctl_wait && t < 3000) begin
            tick();
            t++;
        end
        ok = !ioctl_wait;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic force_write(input logic [15:0] d);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic finish_dl(output bit ok);
        int base = done_cnt;
        int t = 0;
        ioctl_download = 1'b0;
        while (done_cnt == base && t < 3000) begin
            tick();
            t++;
        end
        ok = (done_cnt != base);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_dout = '0;
        swap_mode = SWAP_NONE;
        repeat (3) tick();
        n_vec++;
        if ({ioctl_wait, mem_req, hdr_present, done, overflow, mem_addr, mem_din, rom_size, hdr_offset} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got wait=%b req=%b hdr=%b done=%b ovf=%b addr=%h din=%h size=%h off=%h, want all 0",
                     ioctl_wait, mem_req, hdr_present, done, overflow, mem_addr, mem_din, rom_size, hdr_offset);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        n_vec++;
        if ({ioctl_wait, mem_req, done, rom_size} !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: got wait=%b req=%b done=%b size=%h, want 0", ioctl_wait, mem_req, done, rom_size);
        end
    endtask

    task automatic test_plain_load();
        bit ok, all_ok;
        int d0 = done_cnt;
        all_ok = 1;
        ack_delay = 3;
        swap_mode = SWAP_NONE;
        log_addr.delete();
        log_data.delete();
        start_dl();
        for (int i = 0; i < 8; i++) begin
            write_word(16'(i + 1), ok);
            all_ok &= ok;
        end
        finish_dl(ok);
        all_ok &= ok;
        n_vec++;
        if (!all_ok) begin n_err++; $display("FAIL plain_timeout: got ok=%0b, want 1", all_ok); end
        n_vec++;
        if (log_addr.size() != 8) begin n_err++; $display("FAIL plain_count: got %0d writes, want 8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            n_vec++;
            if (log_addr[i] !== 24'(2 * i) || log_data[i] !== 16'(i + 1)) begin
                n_err++;
                $display("FAIL plain_write%0d: got addr=%h data=%h, want addr=%h data=%h", i, log_addr[i], log_data[i], 2 * i, i + 1);
            end
        end
        n_vec++;
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL plain_done: got %0d pulse cycles, want 1", done_cnt - d0); end
        n_vec++;
        if (rom_size !== 24'd16 || hdr_present !== 1'b0 || hdr_offset !== 24'd0) begin
            n_err++;
            $display("FAIL plain_size: got size=%h hdr=%b off=%h, want 000010 0 000000", rom_size, hdr_present, hdr_offset);
        end
        n_vec++;
        if (proto_err != 0) begin n_err++; $display("FAIL plain_handshake: got %0d early toggles, want 0", proto_err); end
    endtask

    task automatic test_swap();
        logic [15:0] exp_d [4];
        bit ok, all_ok;
        exp_d = '{16'h1280, 16'h4801, 16'h8012, 16'h0148};
        all_ok = 1;
        ack_delay = 2;
        log_addr.delete();
        log_data.delete();
        start_dl();
        for (int m = 0; m < 4; m++) begin
            swap_mode = 2'(m);
            write_word(16'h1280, ok);
            all_ok &= ok;
        end
        swap_mode = SWAP_NONE;
        finish_dl(ok);
        all_ok &= ok;
        n_vec++;
        if (!all_ok || log_data.size() != 4) begin
            n_err++;
            $display("FAIL swap_count: got ok=%0b writes=%0d, want 1 4", all_ok, log_data.size());
        end
        for (int m = 0; m < 4 && m < log_data.size(); m++) begin
            n_vec++;
            if (log_data[m] !== exp_d[m] || log_addr[m] !== 24'(2 * m)) begin
                n_err++;
                $display("FAIL swap_mode%0d: got data=%h addr=%h, want data=%h addr=%h", m, log_data[m], log_addr[m], exp_d[m], 2 * m);
            end
        end
        n_vec++;
        if (rom_size !== 24'd8) begin n_err++; $display("FAIL swap_size: got %h, want 000008", rom_size); end
    endtask

    task automatic test_header(input int nwords, input logic [23:0] exp_size,
                               input logic exp_hdr, input logic [23:0] exp_off);
        bit ok, all_ok;
        all_ok = 1;
        ack_delay = 1;
        log_addr.delete();
        log_data.delete();
        start_dl();
        for (int i = 0; i < nwords; i++) begin
            write_word(16'(i), ok);
            all_ok &= ok;
        end
        finish_dl(ok);
        all_ok &= ok;
        n_vec++;
        if (!all_ok || log_addr.size() != nwords) begin
            n_err++;
            $display("FAIL hdr_count_%0d: got ok=%0b writes=%0d, want 1 %0d", nwords, all_ok, log_addr.size(), nwords);
        end
        n_vec++;
        if (log_addr.size() > 0 && log_addr[log_addr.size() - 1] !== exp_size - 24'd2) begin
            n_err++;
            $display("FAIL hdr_last_addr_%0d: got %h, want %h", nwords, log_addr[log_addr.size() - 1], exp_size - 24'd2);
        end
        n_vec++;
        if (rom_size !== exp_size || hdr_present !== exp_hdr || hdr_offset !== exp_off) begin
            n_err++;
            $display("FAIL hdr_result_%0d: got size=%h hdr=%b off=%h, want size=%h hdr=%b off=%h",
                     nwords, rom_size, hdr_present, hdr_offset, exp_size, exp_hdr, exp_off);
        end
    endtask

    task automatic test_zero_length();
        bit ok;
        int d0 = done_cnt;
        log_addr.delete();
        log_data.delete();
        start_dl();
        finish_dl(ok);
        n_vec++;
        if (!ok || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL zero_done: got ok=%0b pulses=%0d, want 1 1", ok, done_cnt - d0);
        end
        n_vec++;
        if (rom_size !== 24'd0 || hdr_present !== 1'b0 || hdr_offset !== 24'd0) begin
            n_err++;
            $display("FAIL zero_result: got size=%h hdr=%b off=%h, want 0 0 0", rom_size, hdr_present, hdr_offset);
        end
        ioctl_dout = 16'hDEAD;
        ioctl_wr = 1'b1;
        repeat (3) tick();
        ioctl_wr = 1'b0;
        repeat (6) tick();
        n_vec++;
        if (rom_size !== 24'd0 || log_addr.size() != 0) begin
            n_err++;
            $display("FAIL idle_writes_ignored: got size=%h writes=%0d, want 0 0", rom_size, log_addr.size());
        end
    endtask

    task automatic test_back_pressure();
        logic exp_wait [4];
        logic [15:0] exp_d [9];
        bit ok, all_ok;
        exp_wait = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_d = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB006, 16'hB007, 16'hB008, 16'hB009};
        all_ok = 1;
        ack_delay = 20;
        log_addr.delete();
        log_data.delete();
        start_dl();
        for (int i = 0; i < 4; i++) begin
            write_word(16'hB000 + 16'(i), ok);
            all_ok &= ok;
            n_vec++;
            if (ioctl_wait !== exp_wait[i]) begin
                n_err++;
                $display("FAIL bp_wait_after_%0d: got %b, want %b", i + 1, ioctl_wait, exp_wait[i]);
            end
        end
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_no_overflow: got %b, want 0", overflow); end
        force_write(16'hB004);
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_fill_last_slot: got overflow=%b, want 0", overflow); end
        force_write(16'hB005);
        n_vec++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow_set: got %b, want 1", overflow); end
        for (int i = 6; i < 10; i++) begin
            write_word(16'hB000 + 16'(i), ok);
            all_ok &= ok;
        end
        finish_dl(ok);
        all_ok &= ok;
        n_vec++;
        if (!all_ok || log_data.size() != 9) begin
            n_err++;
            $display("FAIL bp_count: got ok=%0b writes=%0d, want 1 9", all_ok, log_data.size());
        end
        for (int i = 0; i < 9 && i < log_data.size(); i++) begin
            n_vec++;
            if (log_data[i] !== exp_d[i] || log_addr[i] !== 24'(2 * i)) begin
                n_err++;
                $display("FAIL bp_write%0d: got data=%h addr=%h, want data=%h addr=%h", i, log_data[i], log_addr[i], exp_d[i], 2 * i);
            end
        end
        n_vec++;
        if (rom_size !== 24'd18 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL bp_final: got size=%h ovf=%b, want 000012 1", rom_size, overflow);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, all_ok;
        int d0;
        all_ok = 1;
        ack_delay = 10;
        start_dl();
        for (int i = 0; i < 3; i++) begin
            write_word(16'hC000 + 16'(i), ok);
            all_ok &= ok;
        end
        repeat (2) tick();
        n_vec++;
        if (mem_req === mem_ack) begin n_err++; $display("FAIL rm_outstanding: got req=%b ack=%b, want differing", mem_req, mem_ack); end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({ioctl_wait, mem_req, hdr_present, done, overflow, mem_addr, mem_din, rom_size, hdr_offset} !== '0) begin
            n_err++;
            $display("FAIL rm_async_clear: got wait=%b req=%b ovf=%b addr=%h din=%h size=%h, want all 0",
                     ioctl_wait, mem_req, overflow, mem_addr, mem_din, rom_size);
        end
        ioctl_download = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        log_addr.delete();
        log_data.delete();
        d0 = done_cnt;
        start_dl();
        write_word(16'hD001, ok);
        all_ok &= ok;
        write_word(16'hD002, ok);
        all_ok &= ok;
        finish_dl(ok);
        all_ok &= ok;
        n_vec++;
        if (!all_ok || log_addr.size() != 2 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL rm_reload: got ok=%0b writes=%0d pulses=%0d, want 1 2 1", all_ok, log_addr.size(), done_cnt - d0);
        end
        n_vec++;
        if (log_addr.size() == 2 && (log_addr[0] !== 24'd0 || log_addr[1] !== 24'd2 ||
                                     log_data[0] !== 16'hD001 || log_data[1] !== 16'hD002)) begin
            n_err++;
            $display("FAIL rm_writes: got %h:%h %h:%h, want 000000:d001 000002:d002", log_addr[0], log_data[0], log_addr[1], log_data[1]);
        end
        n_vec++;
        if (rom_size !== 24'd4) begin n_err++; $display("FAIL rm_size: got %h, want 000004", rom_size); end
    endtask

    task automatic test_restart();
        bit ok, all_ok;
        int d0 = done_cnt;
        int pe0 = proto_err;
        all_ok = 1;
        ack_delay = 10;
        log_addr.delete();
        log_data.delete();
        start_dl();
        for (int i = 0; i < 3; i++) begin
            write_word(16'hE000 + 16'(i), ok);
            all_ok &= ok;
        end
        ioctl_download = 1'b0;
        tick();
        start_dl();
        write_word(16'hF000, ok);
        all_ok &= ok;
        write_word(16'hF001, ok);
        all_ok &= ok;
        finish_dl(ok);
        all_ok &= ok;
        n_vec++;
        if (!all_ok || log_addr.size() != 3 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL rs_count: got ok=%0b writes=%0d pulses=%0d, want 1 3 1", all_ok, log_addr.size(), done_cnt - d0);
        end
        n_vec++;
        if (log_addr.size() == 3 && (log_addr[0] !== 24'd0 || log_data[0] !== 16'hE000 ||
                                     log_addr[1] !== 24'd0 || log_data[1] !== 16'hF000 ||
                                     log_addr[2] !== 24'd2 || log_data[2] !== 16'hF001)) begin
            n_err++;
            $display("FAIL rs_writes: got %h:%h %h:%h %h:%h, want 000000:e000 000000:f000 000002:f001",
                     log_addr[0], log_data[0], log_addr[1], log_data[1], log_addr[2], log_data[2]);
        end
        n_vec++;
        if (proto_err != pe0) begin n_err++; $display("FAIL rs_wait_for_ack: got %0d early toggles, want 0", proto_err - pe0); end
        n_vec++;
        if (rom_size !== 24'd4) begin n_err++; $display("FAIL rs_size: got %h, want 000004", rom_size); end
    endtask

    initial begin
        test_reset();
        test_plain_load();
        test_swap();
        test_header(32'h1100, 24'h002200, 1'b1, 24'h000200);
        test_zero_length();
        test_header(32'h1000, 24'h002000, 1'b0, 24'h000000);
        test_back_pressure();
        test_reset_mid();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Parametrised successor to the inline ROM download path in the TGFX16 top level.
- Accepts ioctl word writes from hps_io and buffers them in a small FIFO, so ioctl_wait throttles only when the FIFO is nearly full.
- Applies a selectable bit/byte swap, then writes each word to the memory controller (ddram) over a toggle req/ack handshake.
- At end of download, reports ROM size and detects a 512-byte copier header, giving the read-side address offset.

Parameters:
- DW, 16, ioctl/memory word width in bits (multiple of 8, 8..64).
- AW, 24, byte-address width of the write port and size counter.
- DEPTH, 4, FIFO depth in words (power of 2, at least 2).
- HDR_BYTES, 512, header size tested for (power of 2).
- HDR_ALIGN, 1024, size alignment used for header detection (power of 2, greater than HDR_BYTES).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  one-cycle word-valid strobe.
- ioctl_dout  in  DW  download data.
- ioctl_wait  out  1  back-pressure to hps_io.
- swap_mode  in  2  transform applied on FIFO write: 0 none; 1 bit-reverse within each byte; 2 byte-reverse within the word; 3 both.
- mem_addr  out  AW  byte address of the current write.
- mem_din  out  DW  data of the current write.
- mem_req  out  1  toggles once per write request.
- mem_ack  in  1  memory echoes mem_req when the write completes.
- rom_size  out  AW  bytes accepted in the current or last download.
- hdr_present  out  1  header detected.
- hdr_offset  out  AW  HDR_BYTES when hdr_present, else 0.
- done  out  1  one-cycle pulse when the download is fully committed.
- overflow  out  1  sticky: an ioctl_wr arrived while the FIFO was full.

Behaviour:
- Reset (reset_n=0, async) clears:
  - all outputs to 0, including mem_req;
  - FIFO pointers and count;
  - the download-edge registers.
- The memory controller must be reset together with this block so that mem_ack=0.
- Download start (ioctl_download 0->1, registered edge detect):
  - flush the FIFO;
  - zero mem_addr, rom_size, hdr_present, hdr_offset and overflow.
  - An in-flight request (mem_req != mem_ack) is not abandoned; the next issue waits for its ack.
- FIFO write:
  - on ioctl_wr with count < DEPTH, push swap(ioctl_dout) and add DW/8 to rom_size;
  - on ioctl_wr with count == DEPTH, drop the word and set overflow.
- ioctl_wait = (count >= DEPTH-1), registered. The one-slot margin covers a strobe arriving in the same cycle wait rises.
- Issue state machine:
  - IDLE -> ISSUE when the FIFO is non-empty and mem_req == mem_ack.
  - ISSUE, one cycle: load mem_din from the FIFO head, pop, toggle mem_req. mem_addr holds the byte address of this word.
  - ISSUE -> WAIT.
  - WAIT -> IDLE when mem_ack == mem_req; mem_addr += DW/8 on that cycle.
  - mem_din and mem_addr stay stable from ISSUE until the ack.
- Simultaneous push and pop in one cycle: count is unchanged, and data ordering is preserved.
- Download end:
  - after ioctl_download 1->0, set a pending flag;
  - when pending, FIFO empty and mem_req == mem_ack, pulse done for one cycle;
  - on that cycle latch hdr_present = (rom_size mod HDR_ALIGN == HDR_BYTES) and hdr_offset = hdr_present ? HDR_BYTES : 0.
  - A zero-length download still pulses done, with rom_size=0 and hdr_present=0.
- Wrap-around: mem_addr and rom_size wrap modulo 2^AW with no flag.
- Writes are ignored while ioctl_download=0.

Decomposition:
- Shared package rom_loader_pkg holds:
  - the swap_mode encoding constants (SWAP_NONE, SWAP_BIT, SWAP_BYTE, SWAP_BOTH);
  - a function swap_word(data, mode), also reusable by other cores.
- One sub-module, sync_fifo (width DW, depth DEPTH, count output, async active-low reset).
- The issue FSM, counters and header logic stay in rom_loader.

Test Plan:
- Plain load: DW=16, swap 0, memory acks 3 cycles after each toggle, 8 words 0x0001..0x0008.
  - Eight toggles at addresses 0x000..0x00E with matching data.
  - done once; rom_size=16; hdr_present=0.
- Header detect: stream 0x2200 bytes (0x1100 words).
  - rom_size=0x2200, hdr_present=1, hdr_offset=0x200.
  - Repeating with 0x2000 bytes gives hdr_present=0.
- Swap: word 0x1280 with mode 1 -> 0x4801; mode 2 -> 0x8012; mode 3 -> 0x0148.
- Back-pressure: ack held off 20 cycles; ioctl_wr every cycle, while honouring ioctl_wait, from the cycle wait is deasserted.
  - ioctl_wait rises once count reaches 3.
  - No overflow and no lost words.
  - A forced write at count 4 sets overflow.
- Reset mid-download: reset_n low with 2 words queued and a request outstanding.
  - All outputs 0 immediately (async).
  - After release and a new download of 2 words: addresses start at 0 and done pulses.
- Restart: download 1->0->1 while the FIFO still holds words.
  - FIFO flushed; address restarts at 0.
  - The first new request is issued only after the outstanding ack.
